lnrv_clint: RTL and testbench

Machine-level timer and software-interrupt block for the lnrv CPU subsystem. It is a responder on the lnrv SRAM-style memory port (cs/we/wem/addr/wdata/rdata, one-cycle read latency), the same protocol the core drives toward its ILM/DLM. It decodes a small register window, maintains a 64-bit `mtime` counter, and drives the core's `tmr_irq` and `sft_irq` inputs.

---
 rtl/lnrv_clint_pkg.sv | 25 ++
 rtl/lnrv_clint_tick.sv | 33 +++
 rtl/lnrv_clint.sv | 132 +++++++++++++
 tb/tb_lnrv_clint.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lnrv_clint_pkg.sv
// Shared register offsets, reset constants and byte-merge helper for the lnrv CLINT.
package lnrv_clint_pkg;

    localparam logic [2:0] LNRV_CLINT_MSIP        = 3'd0;
    localparam logic [2:0] LNRV_CLINT_RSVD1       = 3'd1;
    localparam logic [2:0] LNRV_CLINT_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] LNRV_CLINT_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] LNRV_CLINT_MTIME_LO    = 3'd4;
    localparam logic [2:0] LNRV_CLINT_MTIME_HI    = 3'd5;
    localparam logic [2:0] LNRV_CLINT_CTRL        = 3'd6;

    localparam logic [63:0] LNRV_CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // Replace only the bytes whose write enable is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  wem);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = wem[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/lnrv_clint_tick.sv
// Prescaler for mtime: counts 0..P_TICK_DIV-1 while enabled, pulses tick on the last count.
module lnrv_clint_tick #(
    parameter int unsigned P_TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [15:0] DIV_LAST = 16'(P_TICK_DIV - 1);

    logic [15:0] div_cnt_r;

    assign tick = en && (div_cnt_r == DIV_LAST);

    // Prescaler counter; an mtime write restarts the tick period.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt_r <= 16'd0;
        end else if (clr) begin
            div_cnt_r <= 16'd0;
        end else if (tick) begin
            div_cnt_r <= 16'd0;
        end else if (en) begin
            div_cnt_r <= div_cnt_r + 16'd1;
        end else begin
            div_cnt_r <= div_cnt_r;
        end
    end

endmodule

// File: rtl/lnrv_clint.sv
// lnrv CLINT: msip/mtimecmp/mtime/ctrl register window on the SRAM-style port.
// Optional LNRV_CLINT_DBG_STOP_EN: dbg_halt freezes the timer like tmr_en=0.
module lnrv_clint
    import lnrv_clint_pkg::*;
#(
    parameter int unsigned P_ADDR_WIDTH = 16,
    parameter int unsigned P_TICK_DIV   = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    ram_cs,
    input  logic                    ram_we,
    input  logic [3:0]              ram_wem,
    input  logic [P_ADDR_WIDTH-1:0] ram_addr,
    input  logic [31:0]             ram_wdata,
    output logic [31:0]             ram_rdata,
    input  logic                    dbg_halt,
    output logic                    sft_irq,
    output logic                    tmr_irq
);

    logic        msip_r;
    logic        tmr_en_r;
    logic [63:0] mtimecmp_r;
    logic [63:0] mtime_r;
    logic [31:0] rdata_r;
    logic        tmr_irq_r;

    logic [2:0]  off_s;
    logic        wr_s;
    logic        rd_s;
    logic        wr_mtime_lo_s;
    logic        wr_mtime_hi_s;
    logic        run_s;
    logic        tick_s;
    logic [63:0] mtime_nxt_s;
    logic [31:0] rd_mux_s;
    logic        unused_s;

    assign off_s         = ram_addr[2:0];
    // An all-zero byte mask is treated as no access at all.
    assign wr_s          = ram_cs && ram_we && (ram_wem != 4'b0000);
    assign rd_s          = ram_cs && !ram_we;
    assign wr_mtime_lo_s = wr_s && (off_s == LNRV_CLINT_MTIME_LO);
    assign wr_mtime_hi_s = wr_s && (off_s == LNRV_CLINT_MTIME_HI);
    assign unused_s      = ^{dbg_halt, ram_addr};

`ifdef LNRV_CLINT_DBG_STOP_EN
    assign run_s = tmr_en_r && !dbg_halt;
`else
    assign run_s = tmr_en_r;
`endif

    lnrv_clint_tick #(
        .P_TICK_DIV (P_TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (run_s),
        .clr     (wr_mtime_lo_s || wr_mtime_hi_s),
        .tick    (tick_s)
    );

    // Next mtime: a bus write to either word suppresses that cycle's increment.
    always_comb begin
        mtime_nxt_s = mtime_r;
        if (wr_mtime_lo_s) begin
            mtime_nxt_s[31:0] = byte_merge(mtime_r[31:0], ram_wdata, ram_wem);
        end else if (wr_mtime_hi_s) begin
            mtime_nxt_s[63:32] = byte_merge(mtime_r[63:32], ram_wdata, ram_wem);
        end else if (tick_s) begin
            mtime_nxt_s = mtime_r + 64'd1;
        end else begin
            mtime_nxt_s = mtime_r;
        end
    end

    // Read mux over the pre-edge register values.
    always_comb begin
        rd_mux_s = 32'd0;
        case (off_s)
            LNRV_CLINT_MSIP:        rd_mux_s = {31'd0, msip_r};
            LNRV_CLINT_MTIMECMP_LO: rd_mux_s = mtimecmp_r[31:0];
            LNRV_CLINT_MTIMECMP_HI: rd_mux_s = mtimecmp_r[63:32];
            LNRV_CLINT_MTIME_LO:    rd_mux_s = mtime_r[31:0];
            LNRV_CLINT_MTIME_HI:    rd_mux_s = mtime_r[63:32];
            LNRV_CLINT_CTRL:        rd_mux_s = {31'd0, tmr_en_r};
            default:                rd_mux_s = 32'd0;
        endcase
    end

    // Register file, read data and timer compare.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            msip_r     <= 1'b0;
            tmr_en_r   <= 1'b1;
            mtimecmp_r <= LNRV_CLINT_MTIMECMP_RST;
            mtime_r    <= 64'd0;
            rdata_r    <= 32'd0;
            tmr_irq_r  <= 1'b0;
        end else begin
            mtime_r   <= mtime_nxt_s;
            tmr_irq_r <= (mtime_r >= mtimecmp_r);
            if (rd_s) begin
                rdata_r <= rd_mux_s;
            end
            if (wr_s) begin
                case (off_s)
                    LNRV_CLINT_MSIP: begin
                        if (ram_wem[0]) msip_r <= ram_wdata[0];
                    end
                    LNRV_CLINT_MTIMECMP_LO: begin
                        mtimecmp_r[31:0] <= byte_merge(mtimecmp_r[31:0], ram_wdata, ram_wem);
                    end
                    LNRV_CLINT_MTIMECMP_HI: begin
                        mtimecmp_r[63:32] <= byte_merge(mtimecmp_r[63:32], ram_wdata, ram_wem);
                    end
                    LNRV_CLINT_CTRL: begin
                        if (ram_wem[0]) tmr_en_r <= ram_wdata[0];
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign ram_rdata = rdata_r;
    assign sft_irq   = msip_r;
    assign tmr_irq   = tmr_irq_r;

endmodule

// File: tb/tb_lnrv_clint.sv
// Self-checking bench for lnrv_clint with a 4-cycle prescaler.
module tb_lnrv_clint;

    logic        clk;
    logic        reset_n;
    logic        ram_cs;
    logic        ram_we;
    logic [3:0]  ram_wem;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        dbg_halt;
    logic        sft_irq;
    logic        tmr_irq;

    int n_checks;
    int n_fail;

    typedef struct {
        logic        we;
        logic [3:0]  wem;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        chk_rd;
        logic        exp_tmr;
        logic        exp_sft;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] exp_q[$];

    lnrv_clint #(
        .P_ADDR_WIDTH (16),
        .P_TICK_DIV   (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_wem   (ram_wem),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .dbg_halt  (dbg_halt),
        .sft_irq   (sft_irq),
        .tmr_irq   (tmr_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One single-cycle access; a checked read queues its expectation, popped after the edge.
    task automatic acc(input logic we, input logic [3:0] wem, input logic [15:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp, input logic chk);
        logic [31:0] e;
        ram_cs    = 1'b1;
        ram_we    = we;
        ram_wem   = wem;
        ram_addr  = addr;
        ram_wdata = wdata;
        if (!we && chk) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        ram_cs = 1'b0;
        ram_we = 1'b0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rdata", {32'd0, ram_rdata}, {32'd0, e});
        end
    endtask

    task automatic wr(input logic [15:0] addr, input logic [31:0] wdata);
        acc(1'b1, 4'hF, addr, wdata, 32'd0, 1'b0);
    endtask

    task automatic rd(input logic [15:0] addr, input logic [31:0] exp);
        acc(1'b0, 4'h0, addr, 32'd0, exp, 1'b1);
    endtask

    task automatic add_vec(input logic we, input logic [3:0] wem, input logic [15:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rd,
                           input logic exp_tmr, input logic exp_sft);
        vec_t v;
        v.we      = we;
        v.wem     = wem;
        v.addr    = addr;
        v.wdata   = wdata;
        v.exp_rd  = exp_rd;
        v.chk_rd  = !we;
        v.exp_tmr = exp_tmr;
        v.exp_sft = exp_sft;
        tbl.push_back(v);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        ram_cs    = 1'b0;
        ram_we    = 1'b0;
        ram_wem   = 4'h0;
        ram_addr  = 16'd0;
        ram_wdata = 32'd0;
        dbg_halt  = 1'b0;

        // Reset reads (mtime first, before the first tick), then timer stopped.
        add_vec(1'b0, 4'h0, 16'd4,  32'h0,         32'h0,         1'b0, 1'b0);
        add_vec(1'b0, 4'h0, 16'd5,  32'h0,         32'h0,         1'b0, 1'b0);
        add_vec(1'b0, 4'h0, 16'd0,  32'h0,         32'h0,         1'b0, 1'b0);
        add_vec(1'b0, 4'h0, 16'd1,  32'h0,         32'h0,         1'b0, 1'b0);
        add_vec(1'b0, 4'h0, 16'd2,  32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0);
        add_vec(1'b0, 4'h0, 16'd3,  32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0);
        add_vec(1'b0, 4'h0, 16'd6,  32'h0,         32'h1,         1'b0, 1'b0);
        add_vec(1'b0, 4'h0, 16'd7,  32'h0,         32'h0,         1'b0, 1'b0);
        add_vec(1'b1, 4'hF, 16'd6,  32'h0,         32'h0,         1'b0, 1'b0);
        add_vec(1'b1, 4'hF, 16'd4,  32'h10,        32'h0,         1'b0, 1'b0);
        add_vec(1'b1, 4'hF, 16'd5,  32'h0,         32'h0,         1'b0, 1'b0);
        add_vec(1'b0, 4'h0, 16'd4,  32'h0,         32'h10,        1'b0, 1'b0);
        add_vec(1'b0, 4'h0, 16'd5,  32'h0,         32'h0,         1'b0, 1'b0);
        add_vec(1'b1, 4'hF, 16'd0,  32'hFFFF_FFFF, 32'h0,         1'b0, 1'b1);
        add_vec(1'b0, 4'h0, 16'd0,  32'h0,         32'h1,         1'b0, 1'b1);
        add_vec(1'b1, 4'hF, 16'd0,  32'h0,         32'h0,         1'b0, 1'b0);
        add_vec(1'b1, 4'h3, 16'd2,  32'h1234_5678, 32'h0,         1'b0, 1'b0);
        add_vec(1'b0, 4'h0, 16'd2,  32'h0,         32'hFFFF_5678, 1'b0, 1'b0);
        add_vec(1'b1, 4'h0, 16'd2,  32'h0,         32'h0,         1'b0, 1'b0);
        add_vec(1'b0, 4'h0, 16'd2,  32'h0,         32'hFFFF_5678, 1'b0, 1'b0);
        add_vec(1'b1, 4'hF, 16'd1,  32'hFFFF_FFFF, 32'h0,         1'b0, 1'b0);
        add_vec(1'b0, 4'h0, 16'd1,  32'h0,         32'h0,         1'b0, 1'b0);
        add_vec(1'b1, 4'hF, 16'd6,  32'hFFFF_FFFE, 32'h0,         1'b0, 1'b0);
        add_vec(1'b0, 4'h0, 16'd6,  32'h0,         32'h0,         1'b0, 1'b0);
        add_vec(1'b0, 4'h0, 16'hA,  32'h0,         32'hFFFF_5678, 1'b0, 1'b0);
        add_vec(1'b1, 4'hF, 16'd3,  32'h0,         32'h0,         1'b0, 1'b0);
        add_vec(1'b1, 4'hF, 16'd2,  32'h10,        32'h0,         1'b0, 1'b0);
        add_vec(1'b0, 4'h0, 16'd2,  32'h0,         32'h10,        1'b1, 1'b0);
        add_vec(1'b1, 4'hF, 16'd2,  32'h11,        32'h0,         1'b1, 1'b0);
        add_vec(1'b0, 4'h0, 16'd2,  32'h0,         32'h11,        1'b0, 1'b0);

        idle(3);
        reset_n = 1'b1;
        check("rst_rdata",   {32'd0, ram_rdata}, 64'd0);
        check("rst_tmr_irq", {63'd0, tmr_irq},   64'd0);
        check("rst_sft_irq", {63'd0, sft_irq},   64'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            acc(tbl[i].we, tbl[i].wem, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd, tbl[i].chk_rd);
            check("tbl_tmr_irq", {63'd0, tmr_irq}, {63'd0, tbl[i].exp_tmr});
            check("tbl_sft_irq", {63'd0, sft_irq}, {63'd0, tbl[i].exp_sft});
        end

        // Prescale 4: ticks land 4, 8, 12... edges after the mtime write.
        acc(1'b1, 4'h1, 16'd6, 32'h1, 32'h0, 1'b0);
        wr(16'd5, 32'h0);
        wr(16'd4, 32'h0);
        idle(3);
        rd(16'd4, 32'd0);
        rd(16'd4, 32'd1);
        idle(14);
        rd(16'd4, 32'd4);
        rd(16'd4, 32'd5);

        // Carry into mtime_hi and one-cycle lag of tmr_irq.
        wr(16'd3, 32'h1);
        wr(16'd2, 32'h0);
        wr(16'd5, 32'h0);
        wr(16'd4, 32'hFFFF_FFFE);
        idle(8);
        check("tmr_before_cross", {63'd0, tmr_irq}, 64'd0);
        rd(16'd5, 32'h1);
        check("tmr_after_cross", {63'd0, tmr_irq}, 64'd1);
        rd(16'd4, 32'h0);

        // Byte write on a tick edge wins over the increment.
        wr(16'd5, 32'h0);
        wr(16'd4, 32'h10);
        idle(3);
        acc(1'b1, 4'h2, 16'd4, 32'h0000_AB00, 32'h0, 1'b0);
        rd(16'd5, 32'h0);
        rd(16'd4, 32'h0000_AB10);
        wr(16'd0, 32'h0);
        check("rdata_hold", {32'd0, ram_rdata}, 64'h0000_AB10);

        // Debug halt for 50 cycles.
        dbg_halt = 1'b1;
        wr(16'd4, 32'h0);
        idle(50);
`ifdef LNRV_CLINT_DBG_STOP_EN
        rd(16'd4, 32'd0);
`else
        rd(16'd4, 32'd12);
`endif
        dbg_halt = 1'b0;

        // Reset mid-operation discards the access sampled at that edge.
        wr(16'd0, 32'h1);
        check("sft_set", {63'd0, sft_irq}, 64'd1);
        ram_cs    = 1'b1;
        ram_we    = 1'b1;
        ram_wem   = 4'hF;
        ram_addr  = 16'd6;
        ram_wdata = 32'h0;
        reset_n   = 1'b0;
        @(posedge clk);
        #1;
        ram_cs  = 1'b0;
        ram_we  = 1'b0;
        reset_n = 1'b1;
        check("rst2_sft_irq", {63'd0, sft_irq},   64'd0);
        check("rst2_tmr_irq", {63'd0, tmr_irq},   64'd0);
        check("rst2_rdata",   {32'd0, ram_rdata}, 64'd0);
        rd(16'd6, 32'h1);
        rd(16'd3, 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
